// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder built from one full-adder cell. It computes
//   {cout, sum} = a + b + cin over WIDTH rising edges, LSB first, and pulses
//   done for one cycle when the result registers update.
//
//   Optional feature: define SERIAL_ADDER_OVF_EN to add the ovf output, which
//   flags two's-complement overflow of the last completed add.
//
// Parameters
//   WIDTH  operand/sum width, legal range 2..32
//
// Ports
//   clk    in   clock, all state changes on the rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request an add of a, b, cin (honoured in IDLE or DONE only)
//   a, b   in   operands, sampled only on an accepted start
//   cin    in   carry-in, sampled only on an accepted start
//   busy   out  high while bits are being processed (SHIFT)
//   done   out  one-cycle pulse, sum/cout have just been updated (DONE)
//   sum    out  result of the last completed add, held between completions
//   cout   out  carry-out of the last completed add, held between completions
//   ovf    out  (SERIAL_ADDER_OVF_EN only) signed overflow of the last add
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  // Operand A register doubles as the internal result register: each new sum
  // bit enters its MSB while the consumed operand bit leaves from the LSB.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-adder cell on the current LSBs and the carry flop
  logic s_c;
  logic c_nxt_c;

  always_comb begin
    s_c     = a_q[0] ^ b_q[0] ^ c_q;
    c_nxt_c = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  end

  // State register and datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d   = {s_c, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        c_d   = c_nxt_c;
        cnt_d = cnt_q + CNT_W'(1);
        // Last bit: publish the full result in one step so partial sums never
        // reach the output.
        if (cnt_q == LAST_BIT) begin
          sum_d   = {s_c, a_q[WIDTH-1:1]};
          cout_d  = c_nxt_c;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB, c_nxt_c the carry out of it
          ovf_d   = c_q ^ c_nxt_c;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed self-checking bench for serial_adder: a WIDTH=8 instance for the
//   functional, timing and reset scenarios, and a WIDTH=4 instance swept over
//   every (a, b, cin) combination.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8;
`endif

  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf4;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one add on the 8-bit instance and wait for done. lat counts
  // negedges after the accepting edge up to the one where done is seen;
  // busy_cnt counts negedges with busy high in that window.
  task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                      output int lat, output int busy_cnt);
    @(negedge clk);
    a8 = va; b8 = vb; cin8 = vc; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
               busy8, done8, sum8, cout8);
    end
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 4'h0 || cout4 !== 1'b0) begin
      errors++;
      $display("FAIL reset4: busy=%b done=%b sum=%h cout=%b, required 0 0 0 0",
               busy4, done4, sum4, cout4);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    // 0x00 + 0x00 + 0: latency 9 negedges after the start edge
    run8(8'h00, 8'h00, 1'b0, lat, bc);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL latency_zero: done after %0d cycles, required 9", lat);
    end
    checks++;
    if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL add_zero: {cout,sum}=%b_%h, required 0_00", cout8, sum8);
    end
    // 0xFF + 0x01 wraps
    run8(8'hFF, 8'h01, 1'b0, lat, bc);
    checks++;
    if (lat !== 9 || sum8 !== 8'h00 || cout8 !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: lat=%0d {cout,sum}=%b_%h, required 9 1_00", lat, cout8, sum8);
    end
    // 0x5A + 0xA5 + 1 = 0x100, with busy/done widths
    run8(8'h5A, 8'hA5, 1'b1, lat, bc);
    checks++;
    if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
      errors++;
      $display("FAIL add_5a_a5: {cout,sum}=%b_%h, required 1_00", cout8, sum8);
    end
    checks++;
    if (bc !== 8) begin
      errors++;
      $display("FAIL busy_width: busy high %0d cycles, required 8", bc);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b busy=%b one cycle after done, required 0 0", done8, busy8);
    end
    // Result holds while idle even if operands change
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (sum8 !== 8'h00 || cout8 !== 1'b1 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: {cout,sum}=%b_%h done=%b, required 1_00 0", cout8, sum8, done8);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic partial_seen;
    // 0x12 + 0x34, with a start pulse and operand changes during SHIFT
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    partial_seen = 1'b0;
    n = 1;
    while (done8 !== 1'b1 && n < 40) begin
      // Previous result was 0x00/cout=1 and must not move during SHIFT
      if (sum8 !== 8'h00 || cout8 !== 1'b1) partial_seen = 1'b1;
      if (n == 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else begin
        start8 = 1'b0; a8 = 8'hC3; b8 = 8'h3C;
      end
      @(negedge clk);
      n++;
    end
    start8 = 1'b0;
    checks++;
    if (partial_seen !== 1'b0) begin
      errors++;
      $display("FAIL no_partial: sum/cout changed during SHIFT, required held at 1_00");
    end
    checks++;
    if (n !== 9 || sum8 !== 8'h46 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: lat=%0d {cout,sum}=%b_%h, required 9 0_46", n, cout8, sum8);
    end
    // Start asserted while in DONE: 0x80 + 0x80 + 1 = 0x101
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b after start in DONE, required 1 0", busy8, done8);
    end
    n = 1;
    while (done8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 9 || sum8 !== 8'h01 || cout8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_result: lat=%0d {cout,sum}=%b_%h, required 9 1_01", n, cout8, sum8);
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat, bc;
    logic done_seen;
    @(negedge clk);
    a8 = 8'hA0; b8 = 8'h0B; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    // Advance to the 4th SHIFT cycle
    repeat (3) @(negedge clk);
    checks++;
    if (busy8 !== 1'b1 || sum8 !== 8'h01 || cout8 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: busy=%b {cout,sum}=%b_%h, required 1 1_01", busy8, cout8, sum8);
    end
    // Assert reset between clock edges; outputs must clear with no edge
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
               busy8, done8, sum8, cout8);
    end
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done8 !== 1'b0) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("FAIL aborted_add: done/busy seen after reset, required none");
    end
    // First add after reset: 0x3C + 0x0F = 0x4B
    run8(8'h3C, 8'h0F, 1'b0, lat, bc);
    checks++;
    if (lat !== 9 || sum8 !== 8'h4B || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: lat=%0d {cout,sum}=%b_%h, required 9 0_4b", lat, cout8, sum8);
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    int lat, bc;
    run8(8'h7F, 8'h01, 1'b0, lat, bc);
    checks++;
    if (sum8 !== 8'h80 || ovf8 !== 1'b1 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pos: sum=%h ovf=%b cout=%b, required 80 1 0", sum8, ovf8, cout8);
    end
    run8(8'hFF, 8'h01, 1'b0, lat, bc);
    checks++;
    if (sum8 !== 8'h00 || ovf8 !== 1'b0 || cout8 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_wrap: sum=%h ovf=%b cout=%b, required 00 0 1", sum8, ovf8, cout8);
    end
  endtask
`endif

  task automatic test_exhaustive_w4();
    int n;
    int expv;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          @(negedge clk);
          a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci); start4 = 1'b1;
          @(posedge clk);
          @(negedge clk);
          start4 = 1'b0;
          n = 1;
          while (done4 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
          end
          expv = ai + bi + ci;
          checks++;
          if (n !== 5 || {cout4, sum4} !== 5'(expv)) begin
            errors++;
            $display("FAIL w4_add %0d+%0d+%0d: lat=%0d {cout,sum}=%0d, required 5 %0d",
                     ai, bi, ci, n, {cout4, sum4}, expv);
          end
        end
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_back_to_back();
    test_reset_mid_shift();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_exhaustive_w4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/sum bit width (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to add current a, b, cin.
REQ-005 SHALL have port a  input  WIDTH  operand A, sampled only on an accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B, sampled only on an accepted start.
REQ-007 SHALL have port cin  input  1  carry-in, sampled only on an accepted start.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse: sum/cout just updated.
REQ-010 SHALL have port sum  output  WIDTH  registered result of last completed add.
REQ-011 SHALL have port cout  output  1  registered carry-out of last completed add.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-013 IDLE/DONE + start=1 at an edge SHALL load a, b into operand shift registers, cin into carry flop, clear bit counter, go to SHIFT.
REQ-014 DONE + start=0 SHALL return to IDLE on next edge; IDLE + start=0 SHALL stay in IDLE.
REQ-015 Each SHIFT edge SHALL process one bit LSB-first via one full-adder cell: s = a0^b0^c, c' = a0&b0 | c&(a0^b0); operands shift right, s enters MSB of internal result register.
REQ-016 SHIFT SHALL last exactly WIDTH edges; on the WIDTH-th edge sum <= final result, cout <= final carry, state <= DONE.
REQ-017 Latency: start accepted at edge 0 -> done=1 in the cycle after edge WIDTH; back-to-back throughput one add per WIDTH+1 cycles.
REQ-018 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE.
REQ-019 start while in SHIFT SHALL be ignored; operands and inputs changing during SHIFT SHALL not affect the result.
REQ-020 sum/cout SHALL hold their value between completions; partial results SHALL never appear on sum.
REQ-021 Result SHALL equal (a + b + cin) mod 2^(WIDTH+1) split as {cout, sum}, including all-ones wrap-around.

Reset
REQ-022 rst_n=0 SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, sum=0, cout=0, counter, carry and shift registers to 0.
REQ-023 Reset mid-SHIFT SHALL abort the add with no done pulse; first start after rst_n release SHALL be honoured normally.

Configuration
REQ-024 Macro SERIAL_ADDER_OVF_EN defined: SHALL add port ovf  output  1, registered with sum, = carry into MSB XOR carry out of MSB (two's-complement overflow), reset 0, held between completions.
REQ-025 Macro SERIAL_ADDER_OVF_EN undefined: ovf port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-026 WIDTH=8: a=0x00,b=0x00,cin=0 -> done 9 cycles after start edge, sum=0x00, cout=0; a=0xFF,b=0x01,cin=0 -> sum=0x00, cout=1.
REQ-027 WIDTH=8: a=0x5A,b=0xA5,cin=1 -> sum=0x00, cout=1; busy high for exactly 8 cycles, done high for exactly 1.
REQ-028 Start pulsed again and a,b changed during SHIFT -> ignored; first result (0x12+0x34=0x46, cout=0) unchanged; back-to-back start in DONE accepted.
REQ-029 rst_n low at 4th SHIFT cycle -> busy, done, sum, cout go 0 without waiting for clk; no done pulse; next start yields correct result.
REQ-030 SERIAL_ADDER_OVF_EN defined: 0x7F+0x01 -> sum=0x80, ovf=1, cout=0; 0xFF+0x01 -> ovf=0, cout=1.
REQ-031 WIDTH=4: exhaustive all 512 (a,b,cin) combinations -> {cout,sum} == a+b+cin every time.
